pingpong_counter: RTL and testbench
===================================

Name: pingpong_counter

Overview:
Parametrised bouncing up/down counter on a single clock. An internal two-rate prescaler replaces the separate divided clock: it issues clock-enable strobes, and input x selects the rate. The counter climbs to MAX_VAL, reverses, descends to MIN_VAL, and reverses again. It drives the display/LED stage of the switch-controlled counter designs, with synchronous load and status strobes added.

Parameters:
WIDTH, 4, counter width in bits
MIN_VAL, 0, lower bounce bound; must satisfy MIN_VAL < MAX_VAL
MAX_VAL, 2**WIDTH-1, upper bounce bound; must fit in WIDTH bits
FAST_DIV, 1, clk_1 cycles per step when x=1; must be >=1
SLOW_DIV, 50, clk_1 cycles per step when x=0; must be >=1

Ports:
clk_1  input  1  sole clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
x  input  1  rate select: 1 = FAST_DIV, 0 = SLOW_DIV
en  input  1  run enable; 0 freezes prescaler, counter and mode
load  input  1  synchronous load strobe
load_val  input  WIDTH  load value; clamped to [MIN_VAL, MAX_VAL]
counter  output  WIDTH  current count (registered)
mode  output  1  direction: 0 = up, 1 = down (registered)
tick  output  1  one-cycle pulse in the cycle a step is taken (registered)
bounce  output  1  one-cycle pulse in the cycle mode flips (registered)

Behaviour:
- Reset (async, any time, including mid-step): counter=MIN_VAL, mode=0, tick=0, bounce=0, prescaler=0. The first step after release occurs DIV cycles later.
- Prescaler: the internal counter is sized to clog2(max(FAST_DIV, SLOW_DIV)+1) bits. DIV = x ? FAST_DIV : SLOW_DIV.
  - When en=1 and prescaler == DIV-1: step strobe fires and prescaler clears to 0. Otherwise prescaler increments.
  - x is registered internally. Any change of x clears the prescaler in the same cycle and suppresses the step. The new rate's full period starts afresh.
  - With FAST_DIV=1 and x=1, a step fires every cycle and tick stays high continuously.
- Step action (on the step strobe, registered, visible the cycle after the strobe edge together with tick=1):
  - mode=0 and counter<MAX_VAL: counter+1.
  - mode=0 and counter==MAX_VAL: mode<=1, counter unchanged, bounce=1 (dwell step).
  - mode=1 and counter>MIN_VAL: counter-1.
  - mode=1 and counter==MIN_VAL: mode<=0, counter unchanged, bounce=1.
  - Counter never leaves [MIN_VAL, MAX_VAL]. No wrap-around.
- Load (priority over step):
  - counter <= clamp(load_val), prescaler <= 0. mode is unchanged. tick=0, bounce=0 in that cycle.
  - If the loaded value lies outside the bounds it is clamped; no other error indication.
- en=0: all state holds, tick=0, bounce=0. load is still honoured while en=0.
- Priority order: rst > load > x-change > step > hold.
- tick and bounce are single-cycle, except for the FAST_DIV=1 continuous case above.
- Full up-down cycle length in steps: 2*(MAX_VAL-MIN_VAL)+2.

Test Plan:
- WIDTH=4, FAST_DIV=1, x=1, en=1 after reset -> counter steps 0..15 once per cycle. At 15 one dwell step sets mode=1 with bounce=1, then 14..0, dwell, mode=0. Period is 32 steps.
- SLOW_DIV=5, x=0 -> tick pulses every 5 cycles, 1 cycle wide. Counter increments only on tick cycles. First tick occurs 5 cycles after reset release.
- Toggle x from 0 to 1 when prescaler=3 -> no step that cycle. With FAST_DIV=3, the next step comes exactly 3 cycles later. Counter and mode are unchanged by the switch.
- load=1, load_val=9 while mode=1 -> counter=9, mode stays 1. The next step yields 8 after a full DIV. With MIN_VAL=2, load_val=0 -> counter=2.
- en=0 for 7 cycles mid-count at counter=6 -> counter, mode and prescaler frozen, tick=0. Resumes with the remaining prescaler count.
- Assert rst asynchronously between clk_1 edges while counter=12, mode=1 -> outputs go immediately to 0/0/0/0. On release, counting restarts upward from MIN_VAL.

Source files
------------

// File: rtl/pingpong_counter_if.sv
// Control and status bundle for pingpong_counter: run/rate/load controls in,
// registered count, direction and strobes out.
interface pingpong_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             x;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] counter;
  logic             mode;
  logic             tick;
  logic             bounce;

  modport master (
    output x, en, load, load_val,
    input  counter, mode, tick, bounce
  );

  modport slave (
    input  x, en, load, load_val,
    output counter, mode, tick, bounce
  );
endinterface

// File: rtl/pingpong_counter.sv
// Bouncing up/down counter between MIN_VAL and MAX_VAL, stepped by an internal
// two-rate prescaler strobe; synchronous clamped load and tick/bounce strobes.
module pingpong_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned FAST_DIV = 1,
  parameter int unsigned SLOW_DIV = 50
) (
  input logic               clk_1,
  input logic               rst,
  pingpong_counter_if.slave bus
);
  localparam int unsigned MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
  localparam int unsigned PW      = $clog2(MAX_DIV + 1);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q;
  logic             mode_q;
  logic             tick_q;
  logic             bounce_q;
  logic [PW-1:0]    presc_q;
  logic             x_q;
  // x_q only becomes a valid reference after its first capture, so a rate
  // input held through reset does not count as a change on release.
  logic             x_seen_q;

  logic [PW-1:0]    div_m1;
  logic             x_chg;
  logic [WIDTH-1:0] load_clamped;

  assign div_m1 = bus.x ? PW'(FAST_DIV - 1) : PW'(SLOW_DIV - 1);
  assign x_chg  = x_seen_q & (bus.x ^ x_q);

  always_comb begin
    load_clamped = bus.load_val;
    if (bus.load_val <= MIN_V) begin
      load_clamped = MIN_V;
    end else if (bus.load_val >= MAX_V) begin
      load_clamped = MAX_V;
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      cnt_q    <= MIN_V;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      bounce_q <= 1'b0;
      presc_q  <= '0;
      x_q      <= 1'b0;
      x_seen_q <= 1'b0;
    end else begin
      tick_q   <= 1'b0;
      bounce_q <= 1'b0;
      if (bus.load) begin
        cnt_q    <= load_clamped;
        presc_q  <= '0;
        x_q      <= bus.x;
        x_seen_q <= 1'b1;
      end else if (bus.en) begin
        x_q      <= bus.x;
        x_seen_q <= 1'b1;
        if (x_chg) begin
          presc_q <= '0;
        end else if (presc_q == div_m1) begin
          presc_q <= '0;
          tick_q  <= 1'b1;
          // Reaching a bound costs one dwell step that only flips direction.
          if (!mode_q) begin
            if (cnt_q == MAX_V) begin
              mode_q   <= 1'b1;
              bounce_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + WIDTH'(1);
            end
          end else begin
            if (cnt_q == MIN_V) begin
              mode_q   <= 1'b0;
              bounce_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - WIDTH'(1);
            end
          end
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  assign bus.counter = cnt_q;
  assign bus.mode    = mode_q;
  assign bus.tick    = tick_q;
  assign bus.bounce  = bounce_q;
endmodule

// File: tb/tb_pingpong_counter.sv
// Directed bench for pingpong_counter: two instances (fast-step and bounded/slow)
// checked as {counter, mode, tick, bounce} against hand-computed vectors.
module tb_pingpong_counter;
  logic clk_1 = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_1 = ~clk_1;

  pingpong_counter_if #(.WIDTH(4)) bus_a ();
  pingpong_counter_if #(.WIDTH(4)) bus_b ();

  pingpong_counter #(
    .WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .FAST_DIV(1), .SLOW_DIV(5)
  ) dut_a (
    .clk_1(clk_1),
    .rst  (rst),
    .bus  (bus_a)
  );

  pingpong_counter #(
    .WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .FAST_DIV(3), .SLOW_DIV(5)
  ) dut_b (
    .clk_1(clk_1),
    .rst  (rst),
    .bus  (bus_b)
  );

  wire [6:0] obs_a = {bus_a.counter, bus_a.mode, bus_a.tick, bus_a.bounce};
  wire [6:0] obs_b = {bus_b.counter, bus_b.mode, bus_b.tick, bus_b.bounce};

  task automatic cyc();
    @(posedge clk_1);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    rst = 1'b1;
    bus_a.x = 1'b1; bus_a.en = 1'b1; bus_a.load = 1'b0; bus_a.load_val = 4'd0;
    bus_b.x = 1'b0; bus_b.en = 1'b0; bus_b.load = 1'b0; bus_b.load_val = 4'd0;
    repeat (2) cyc();
    exp = {4'd0, 3'b000};
    total++;
    if (obs_a !== exp) begin
      bad++;
      $display("FAIL reset_a: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_a[6:3], obs_a[2], obs_a[1], obs_a[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
    exp = {4'd2, 3'b000};
    total++;
    if (obs_b !== exp) begin
      bad++;
      $display("FAIL reset_b: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Fast rate, DIV=1: one step per cycle, dwell at 15 and at 0, 32-step period.
  task automatic test_fast_bounce();
    logic [6:0] exp;
    int   exp_c = 0;
    logic exp_m = 1'b0;
    logic exp_b;
    int   b1 = -1;
    int   b2 = -1;
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      cyc();
      exp_b = 1'b0;
      if (!exp_m) begin
        if (exp_c == 15) begin exp_m = 1'b1; exp_b = 1'b1; end
        else exp_c++;
      end else begin
        if (exp_c == 0) begin exp_m = 1'b0; exp_b = 1'b1; end
        else exp_c--;
      end
      exp = {4'(exp_c), exp_m, 1'b1, exp_b};
      total++;
      if (obs_a !== exp) begin
        bad++;
        $display("FAIL fast_step k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", k,
                 obs_a[6:3], obs_a[2], obs_a[1], obs_a[0], exp[6:3], exp[2], exp[1], exp[0]);
      end
      if (bus_a.bounce === 1'b1) begin
        if (b1 < 0) b1 = k;
        else if (b2 < 0) b2 = k;
      end
    end
    total++;
    if (b1 !== 16 || b2 !== 32) begin
      bad++;
      $display("FAIL fast_period: got bounces at %0d,%0d want 16,32", b1, b2);
    end
    bus_a.en = 1'b0;
  endtask

  // Slow rate DIV=5 from a fresh reset: first tick 5 cycles after release.
  task automatic test_slow_rate();
    logic [6:0] exp;
    bus_b.x = 1'b0;
    bus_b.en = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      exp = {4'(2 + k / 5), 1'b0, (k % 5 == 0), 1'b0};
      total++;
      if (obs_b !== exp) begin
        bad++;
        $display("FAIL slow_rate k=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", k,
                 obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // Prescaler sits at 3; switching to x=1 restarts a full 3-cycle period.
  task automatic test_x_switch();
    logic [6:0] exp;
    bus_b.x = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      cyc();
      exp = (j == 4) ? {4'd5, 3'b010} : {4'd4, 3'b000};
      total++;
      if (obs_b !== exp) begin
        bad++;
        $display("FAIL x_switch j=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", j,
                 obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_load();
    logic [6:0] exp;
    // 7 steps up to 12 then the dwell step, 3 cycles each.
    repeat (24) cyc();
    exp = {4'd12, 3'b111};
    total++;
    if (obs_b !== exp) begin
      bad++;
      $display("FAIL top_bounce: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
    cyc();
    exp = {4'd12, 3'b100};
    total++;
    if (obs_b !== exp) begin
      bad++;
      $display("FAIL pulse_width: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
    bus_b.load = 1'b1; bus_b.load_val = 4'd9;
    cyc();
    bus_b.load = 1'b0;
    exp = {4'd9, 3'b100};
    total++;
    if (obs_b !== exp) begin
      bad++;
      $display("FAIL load_9: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
    for (int j = 1; j <= 3; j++) begin
      cyc();
      exp = (j == 3) ? {4'd8, 3'b110} : {4'd9, 3'b100};
      total++;
      if (obs_b !== exp) begin
        bad++;
        $display("FAIL after_load j=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", j,
                 obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
    bus_b.load = 1'b1; bus_b.load_val = 4'd0;
    cyc();
    exp = {4'd2, 3'b100};
    total++;
    if (obs_b !== exp) begin
      bad++;
      $display("FAIL clamp_low: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
    bus_b.load_val = 4'd15;
    cyc();
    exp = {4'd12, 3'b100};
    total++;
    if (obs_b !== exp) begin
      bad++;
      $display("FAIL clamp_high: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
    bus_b.en = 1'b0; bus_b.load_val = 4'd7;
    cyc();
    bus_b.load = 1'b0;
    exp = {4'd7, 3'b100};
    total++;
    if (obs_b !== exp) begin
      bad++;
      $display("FAIL load_while_off: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Slow rate on dut_a: 2 counts, 7 frozen cycles, then 3 more counts to the step.
  task automatic test_enable_freeze();
    logic [6:0] exp;
    exp = {4'd6, 3'b000};
    bus_a.x = 1'b0; bus_a.en = 1'b0; bus_a.load = 1'b1; bus_a.load_val = 4'd6;
    cyc();
    bus_a.load = 1'b0;
    bus_a.en = 1'b1;
    repeat (2) cyc();
    bus_a.en = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      cyc();
      total++;
      if (obs_a !== exp) begin
        bad++;
        $display("FAIL frozen j=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", j,
                 obs_a[6:3], obs_a[2], obs_a[1], obs_a[0], exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
    bus_a.en = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      exp = (j == 3) ? {4'd7, 3'b010} : {4'd6, 3'b000};
      total++;
      if (obs_a !== exp) begin
        bad++;
        $display("FAIL resume j=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", j,
                 obs_a[6:3], obs_a[2], obs_a[1], obs_a[0], exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
    bus_a.en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [6:0] exp;
    bus_b.load = 1'b1; bus_b.load_val = 4'd12;
    cyc();
    bus_b.load = 1'b0;
    exp = {4'd12, 3'b100};
    total++;
    if (obs_b !== exp) begin
      bad++;
      $display("FAIL pre_reset: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
    bus_b.en = 1'b1;
    cyc();
    #3 rst = 1'b1;
    #1;
    exp = {4'd2, 3'b000};
    total++;
    if (obs_b !== exp) begin
      bad++;
      $display("FAIL async_rst_b: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
    exp = {4'd0, 3'b000};
    total++;
    if (obs_a !== exp) begin
      bad++;
      $display("FAIL async_rst_a: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               obs_a[6:3], obs_a[2], obs_a[1], obs_a[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
    cyc();
    rst = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      exp = (j == 3) ? {4'd3, 3'b010} : {4'd2, 3'b000};
      total++;
      if (obs_b !== exp) begin
        bad++;
        $display("FAIL restart j=%0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", j,
                 obs_b[6:3], obs_b[2], obs_b[1], obs_b[0], exp[6:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fast_bounce();
    test_slow_rate();
    test_x_switch();
    test_load();
    test_enable_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
